daisy_master: RTL and testbench
===============================

DAISY_MASTER -- requirements
Module: daisy_master

Interface
REQ-001 Parameter: DATA_LEN, default `DATA_LEN, payload bits per frame.
REQ-002 Parameter: CMD_LEN, default `CMD_LEN, command bits per frame.
REQ-003 Parameter: ACK_CYCLES, default 2, cycles the line is released between command and data phase.
REQ-004 Parameter: GAP_CYCLES, default 2, cycles the line is driven low after each frame.
REQ-005 clk  input  1  single clock; all logic on posedge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 cmd_valid  input  1  host requests a frame.
REQ-008 cmd_ready  output  1  block accepts a request this cycle.
REQ-009 cmd_code  input  CMD_LEN  command of type ctrl command (START_SND_CMD, START_RCV_CMD, RESET_CMD, UPDATE_CMD).
REQ-010 wr_data  input  DATA_LEN  payload for START_RCV_CMD frames.
REQ-011 data_inout  inout  1  bidirectional daisychain line to the first chain node.
REQ-012 rd_data  output  DATA_LEN  payload captured in START_SND_CMD frames.
REQ-013 rd_valid  output  1  one-cycle pulse: rd_data updated.
REQ-014 busy  output  1  frame in progress.
REQ-015 state_debug  output  3  current state encoding.

Function
REQ-016 States: IDLE, START, CMD, ACK, WR_DATA, RD_DATA, GAP; one registered state, one bit counter sized $clog2(max(DATA_LEN,CMD_LEN,ACK_CYCLES,GAP_CYCLES)+1).
REQ-017 cmd_ready = 1 only in IDLE; busy = not IDLE; handshake completes on posedge with cmd_valid && cmd_ready.
REQ-018 On handshake: cmd_code and wr_data latched; next state START; cmd_valid when not ready is ignored (no queueing).
REQ-019 START: exactly 1 cycle, line driven 1; -> CMD.
REQ-020 CMD: CMD_LEN cycles, line driven with latched command, MSB first, one bit per cycle; -> ACK.
REQ-021 ACK: ACK_CYCLES cycles, line released (Z); -> WR_DATA if START_RCV_CMD, RD_DATA if START_SND_CMD, GAP for RESET_CMD, UPDATE_CMD, or any other code.
REQ-022 WR_DATA: DATA_LEN cycles, line driven with latched wr_data, bit DATA_LEN-1 first; -> GAP.
REQ-023 RD_DATA: DATA_LEN cycles, line released; line sampled each posedge and shifted into a capture register LSB-in (first sampled bit ends at bit DATA_LEN-1); -> GAP.
REQ-024 On RD_DATA exit: rd_data <= capture register and rd_valid = 1 for exactly the following cycle; rd_data holds until next completed read.
REQ-025 GAP: GAP_CYCLES cycles, line driven 0; -> IDLE.
REQ-026 Line drive: driven 0 in IDLE and GAP, driven per REQ-019/020/022, released only in ACK and RD_DATA; output enable and output value registered (glitch-free, no comb path from cmd_* to the line).
REQ-027 Frame length, handshake to cmd_ready high again: 1+CMD_LEN+ACK_CYCLES+(DATA_LEN if data frame)+GAP_CYCLES cycles.
REQ-028 Back-to-back: with cmd_valid held high, next handshake occurs on the first IDLE cycle; no extra idle cycle is inserted.
REQ-029 Counter reloads to 0 on every state change; no wrap-around occurs inside a state.
REQ-030 rd_data is unchanged by write, reset and update frames.

Reset
REQ-031 reset low asserts immediately, independent of clk: state IDLE, counter 0, line driven 0, cmd_ready 0 while reset low then 1 on the first clk after release, busy 0, rd_valid 0, rd_data 0, state_debug = IDLE encoding.
REQ-032 reset mid-frame aborts the frame; no rd_valid pulse; line returns to driven 0 within the reset assertion.

Verification (DATA_LEN=8, CMD_LEN=2, ACK_CYCLES=2, GAP_CYCLES=2)
REQ-033 Write START_RCV_CMD, wr_data=0xA5 -> line: 1, cmd bits, Z,Z, 1,0,1,0,0,1,0,1, 0,0; busy high 15 cycles; cmd_ready high on cycle 16.
REQ-034 Read START_SND_CMD, bench model drives 0x3C MSB first during RD_DATA -> rd_data=0x3C, rd_valid single pulse on cycle after last sample; line never driven by the block during RD_DATA.
REQ-035 RESET_CMD then UPDATE_CMD, cmd_valid held high -> two 7-cycle frames back-to-back, no data phase, rd_data unchanged.
REQ-036 Assert reset in WR_DATA bit 3 -> line driven 0 same cycle, state IDLE, no rd_valid; next request completes normally.
REQ-037 Pulse cmd_valid while busy -> ignored; exactly one frame observed on the line.

Source files
------------

// File: rtl/daisy_master.sv
// Daisychain bus master: serialises one command frame per host request onto a
// single bidirectional line (start bit, command, ack gap, optional data, trailer).
`ifndef DATA_LEN
`define DATA_LEN 8
`endif
`ifndef CMD_LEN
`define CMD_LEN 2
`endif

module daisy_master #(
  parameter int DATA_LEN   = `DATA_LEN,
  parameter int CMD_LEN    = `CMD_LEN,
  parameter int ACK_CYCLES = 2,
  parameter int GAP_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [CMD_LEN-1:0]  cmd_code,
  input  logic [DATA_LEN-1:0] wr_data,
  inout  wire                 data_inout,
  output logic [DATA_LEN-1:0] rd_data,
  output logic                rd_valid,
  output logic                busy,
  output logic [2:0]          state_debug
);

  localparam logic [CMD_LEN-1:0] RESET_CMD     = CMD_LEN'(0);
  localparam logic [CMD_LEN-1:0] START_SND_CMD = CMD_LEN'(1);
  localparam logic [CMD_LEN-1:0] START_RCV_CMD = CMD_LEN'(2);
  localparam logic [CMD_LEN-1:0] UPDATE_CMD    = CMD_LEN'(3);

  localparam int M1    = (DATA_LEN > CMD_LEN) ? DATA_LEN : CMD_LEN;
  localparam int M2    = (ACK_CYCLES > GAP_CYCLES) ? ACK_CYCLES : GAP_CYCLES;
  localparam int MAXC  = (M1 > M2) ? M1 : M2;
  localparam int CNT_W = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    CMD     = 3'd2,
    ACK     = 3'd3,
    WR_DATA = 3'd4,
    RD_DATA = 3'd5,
    GAP     = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, last_cnt;
  logic [CMD_LEN-1:0]  cmd_q, cmd_d, cmd_sh_q, cmd_sh_d;
  logic [DATA_LEN-1:0] wr_sh_q, wr_sh_d;
  logic [DATA_LEN-2:0] cap_q, cap_d;
  logic [DATA_LEN-1:0] rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                oe_q, oe_d, out_q, out_d;
  logic                init_q;
  logic                last, hs;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cmd_q      <= '0;
      cmd_sh_q   <= '0;
      wr_sh_q    <= '0;
      cap_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      oe_q       <= 1'b1;
      out_q      <= 1'b0;
      init_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      cmd_sh_q   <= cmd_sh_d;
      wr_sh_q    <= wr_sh_d;
      cap_q      <= cap_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      oe_q       <= oe_d;
      out_q      <= out_d;
      init_q     <= 1'b1;
    end
  end

  // init_q keeps cmd_ready low until the first clock after reset release
  assign cmd_ready   = (state_q == IDLE) && init_q;
  assign busy        = (state_q != IDLE);
  assign state_debug = state_q;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign hs          = cmd_valid && cmd_ready;

  always_comb begin
    case (state_q)
      CMD:             last_cnt = CNT_W'(CMD_LEN - 1);
      ACK:             last_cnt = CNT_W'(ACK_CYCLES - 1);
      WR_DATA,
      RD_DATA:         last_cnt = CNT_W'(DATA_LEN - 1);
      GAP:             last_cnt = CNT_W'(GAP_CYCLES - 1);
      default:         last_cnt = '0;
    endcase
  end
  assign last = (cnt_q == last_cnt);

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    cmd_sh_d   = cmd_sh_q;
    wr_sh_d    = wr_sh_q;
    cap_d      = cap_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    case (state_q)
      IDLE: if (hs) begin
        state_d  = START;
        cmd_d    = cmd_code;
        cmd_sh_d = cmd_code;
        wr_sh_d  = wr_data;
      end
      START: state_d = CMD;
      CMD: begin
        cmd_sh_d = cmd_sh_q << 1;
        if (last) state_d = ACK;
      end
      ACK: if (last) begin
        case (cmd_q)
          START_RCV_CMD: state_d = WR_DATA;
          START_SND_CMD: state_d = RD_DATA;
          default:       state_d = GAP;
        endcase
      end
      WR_DATA: begin
        wr_sh_d = wr_sh_q << 1;
        if (last) state_d = GAP;
      end
      RD_DATA: begin
        cap_d = (cap_q << 1) | (DATA_LEN-1)'(data_inout);
        if (last) begin
          state_d    = GAP;
          rd_data_d  = {cap_q, data_inout};
          rd_valid_d = 1'b1;
        end
      end
      GAP: if (last) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    cnt_d = cnt_q + CNT_W'(1);
    if (state_d != state_q || state_q == IDLE) cnt_d = '0;

    // Line drive is computed from next state so the registered pin tracks the state
    oe_d  = 1'b1;
    out_d = 1'b0;
    case (state_d)
      START:        out_d = 1'b1;
      CMD:          out_d = cmd_sh_d[CMD_LEN-1];
      WR_DATA:      out_d = wr_sh_d[DATA_LEN-1];
      ACK, RD_DATA: oe_d  = 1'b0;
      default:      ;
    endcase
  end

  assign data_inout = oe_q ? out_q : 1'bz;

  logic unused_codes;
  assign unused_codes = ^{RESET_CMD, UPDATE_CMD};

endmodule

// File: tb/tb_daisy_master.sv
// Directed bench for daisy_master: frame waveforms, read capture, back-to-back,
// busy-time request rejection and asynchronous abort.
module tb_daisy_master;

  localparam logic [1:0] C_RESET = 2'd0;
  localparam logic [1:0] C_SND   = 2'd1;
  localparam logic [1:0] C_RCV   = 2'd2;
  localparam logic [1:0] C_UPD   = 2'd3;

  logic       clk, reset, cmd_valid, cmd_ready;
  logic [1:0] cmd_code;
  logic [7:0] wr_data, rd_data;
  logic       rd_valid, busy;
  logic [2:0] state_debug;
  logic       tb_oe, tb_val;
  wire        data_line;

  int vec_cnt = 0;
  int err_cnt = 0;

  assign data_line = tb_oe ? tb_val : 1'bz;

  daisy_master #(.DATA_LEN(8), .CMD_LEN(2), .ACK_CYCLES(2), .GAP_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_code(cmd_code), .wr_data(wr_data), .data_inout(data_line),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .state_debug(state_debug)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    vec_cnt++; if ({state_debug, busy, cmd_ready, rd_valid} !== 6'b000_000) begin
      err_cnt++; $display("FAIL rst_ctrl got st=%0d busy=%b rdy=%b rv=%b exp 0", state_debug, busy, cmd_ready, rd_valid); end
    vec_cnt++; if (rd_data !== 8'h00) begin
      err_cnt++; $display("FAIL rst_rd_data got=%h exp=00", rd_data); end
    vec_cnt++; if (dut.oe_q !== 1'b1 || data_line !== 1'b0) begin
      err_cnt++; $display("FAIL rst_line got oe=%b line=%b exp oe=1 line=0", dut.oe_q, data_line); end
    repeat (2) @(negedge clk);
    vec_cnt++; if (cmd_ready !== 1'b0) begin
      err_cnt++; $display("FAIL rst_ready_held got=%b exp=0", cmd_ready); end
    reset = 1'b1;
    #1;
    vec_cnt++; if (cmd_ready !== 1'b0) begin
      err_cnt++; $display("FAIL rst_ready_release got=%b exp=0", cmd_ready); end
    @(negedge clk);
    vec_cnt++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      err_cnt++; $display("FAIL rst_ready_first_clk got rdy=%b busy=%b exp rdy=1 busy=0", cmd_ready, busy); end
  endtask

  task automatic test_write();
    logic [14:0] exp_line, exp_oe;
    exp_line = 15'b1_10_00_10100101_00;
    exp_oe   = 15'b1_11_00_11111111_11;
    @(negedge clk);
    vec_cnt++; if (cmd_ready !== 1'b1) begin
      err_cnt++; $display("FAIL wr_ready_pre got=%b exp=1", cmd_ready); end
    cmd_valid = 1'b1; cmd_code = C_RCV; wr_data = 8'hA5;
    @(posedge clk); #1 cmd_valid = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k <= 15) begin
        vec_cnt++; if (busy !== 1'b1 || cmd_ready !== 1'b0 || rd_valid !== 1'b0) begin
          err_cnt++; $display("FAIL wr_busy cyc=%0d got busy=%b rdy=%b rv=%b exp 1,0,0", k, busy, cmd_ready, rd_valid); end
        vec_cnt++; if (dut.oe_q !== exp_oe[15-k]) begin
          err_cnt++; $display("FAIL wr_oe cyc=%0d got=%b exp=%b", k, dut.oe_q, exp_oe[15-k]); end
        if (exp_oe[15-k]) begin
          vec_cnt++; if (data_line !== exp_line[15-k]) begin
            err_cnt++; $display("FAIL wr_line cyc=%0d got=%b exp=%b", k, data_line, exp_line[15-k]); end
        end
      end else begin
        vec_cnt++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || data_line !== 1'b0) begin
          err_cnt++; $display("FAIL wr_end got busy=%b rdy=%b line=%b exp 0,1,0", busy, cmd_ready, data_line); end
        vec_cnt++; if (rd_data !== 8'h00) begin
          err_cnt++; $display("FAIL wr_rd_data_kept got=%h exp=00", rd_data); end
      end
      if (k == 1)  begin vec_cnt++; if (state_debug !== 3'd1) begin err_cnt++; $display("FAIL wr_st_start got=%0d exp=1", state_debug); end end
      if (k == 4)  begin vec_cnt++; if (state_debug !== 3'd3) begin err_cnt++; $display("FAIL wr_st_ack got=%0d exp=3", state_debug); end end
      if (k == 6)  begin vec_cnt++; if (state_debug !== 3'd4) begin err_cnt++; $display("FAIL wr_st_wr got=%0d exp=4", state_debug); end end
      if (k == 14) begin vec_cnt++; if (state_debug !== 3'd6) begin err_cnt++; $display("FAIL wr_st_gap got=%0d exp=6", state_debug); end end
    end
  endtask

  task automatic test_read();
    logic [14:0] exp_line, exp_oe;
    logic [7:0]  pat;
    int          pulses;
    exp_line = 15'b1_01_00_00000000_00;
    exp_oe   = 15'b1_11_00_00000000_11;
    pat      = 8'h3C;
    pulses   = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_code = C_SND; wr_data = 8'hFF;
    @(posedge clk); #1 cmd_valid = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      tb_oe  = (k >= 6 && k <= 13);
      tb_val = (k >= 6 && k <= 13) ? pat[13-k] : 1'b0;
      #1;
      if (rd_valid === 1'b1) pulses++;
      if (k <= 15) begin
        vec_cnt++; if (dut.oe_q !== exp_oe[15-k]) begin
          err_cnt++; $display("FAIL rd_oe cyc=%0d got=%b exp=%b", k, dut.oe_q, exp_oe[15-k]); end
        if (exp_oe[15-k]) begin
          vec_cnt++; if (data_line !== exp_line[15-k]) begin
            err_cnt++; $display("FAIL rd_line cyc=%0d got=%b exp=%b", k, data_line, exp_line[15-k]); end
        end
      end
      if (k == 6) begin vec_cnt++; if (state_debug !== 3'd5) begin err_cnt++; $display("FAIL rd_st got=%0d exp=5", state_debug); end end
      if (k == 13) begin
        vec_cnt++; if (rd_data !== 8'h00 || rd_valid !== 1'b0) begin
          err_cnt++; $display("FAIL rd_early got data=%h rv=%b exp 00,0", rd_data, rd_valid); end
      end
      if (k == 14) begin
        vec_cnt++; if (rd_valid !== 1'b1 || rd_data !== 8'h3C) begin
          err_cnt++; $display("FAIL rd_capture got rv=%b data=%h exp 1,3c", rd_valid, rd_data); end
      end
      if (k == 16) begin
        vec_cnt++; if (rd_data !== 8'h3C || cmd_ready !== 1'b1) begin
          err_cnt++; $display("FAIL rd_hold got data=%h rdy=%b exp 3c,1", rd_data, cmd_ready); end
      end
    end
    vec_cnt++; if (pulses != 1) begin
      err_cnt++; $display("FAIL rd_pulse_count got=%0d exp=1", pulses); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_line, exp_oe, exp_busy;
    exp_line = 16'b1000000_0_1110000_0;
    exp_oe   = 16'b1110011_1_1110011_1;
    exp_busy = 16'b1111111_0_1111111_0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_code = C_RESET;
    @(posedge clk); #1 cmd_code = C_UPD;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      vec_cnt++; if (busy !== exp_busy[16-k] || dut.oe_q !== exp_oe[16-k]) begin
        err_cnt++; $display("FAIL b2b_busy_oe cyc=%0d got busy=%b oe=%b exp busy=%b oe=%b", k, busy, dut.oe_q, exp_busy[16-k], exp_oe[16-k]); end
      if (exp_oe[16-k]) begin
        vec_cnt++; if (data_line !== exp_line[16-k]) begin
          err_cnt++; $display("FAIL b2b_line cyc=%0d got=%b exp=%b", k, data_line, exp_line[16-k]); end
      end
      vec_cnt++; if (rd_data !== 8'h3C || rd_valid !== 1'b0) begin
        err_cnt++; $display("FAIL b2b_rd cyc=%0d got data=%h rv=%b exp 3c,0", k, rd_data, rd_valid); end
      if (k == 6 || k == 14) begin
        vec_cnt++; if (state_debug !== 3'd6) begin err_cnt++; $display("FAIL b2b_no_data cyc=%0d got=%0d exp=6", k, state_debug); end
      end
      if (k == 8) begin
        vec_cnt++; if (cmd_ready !== 1'b1) begin err_cnt++; $display("FAIL b2b_ready got=%b exp=1", cmd_ready); end
        @(posedge clk); #1 cmd_valid = 1'b0;
      end
    end
  endtask

  task automatic test_ignore_busy();
    int   busy_cyc, starts;
    logic prev;
    busy_cyc = 0; starts = 0; prev = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_code = C_RESET;
    @(posedge clk); #1 cmd_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cyc++;
      if (dut.oe_q === 1'b1 && data_line === 1'b1 && !prev) starts++;
      prev = (dut.oe_q === 1'b1) && (data_line === 1'b1);
      if (k == 3) begin
        cmd_valid = 1'b1; cmd_code = C_SND;
        @(posedge clk); #1 cmd_valid = 1'b0;
      end
    end
    vec_cnt++; if (busy_cyc != 7) begin
      err_cnt++; $display("FAIL ign_busy_cycles got=%0d exp=7", busy_cyc); end
    vec_cnt++; if (starts != 1) begin
      err_cnt++; $display("FAIL ign_frames got=%0d exp=1", starts); end
    vec_cnt++; if (state_debug !== 3'd0 || rd_data !== 8'h3C) begin
      err_cnt++; $display("FAIL ign_end got st=%0d data=%h exp 0,3c", state_debug, rd_data); end
  endtask

  task automatic test_abort();
    logic [7:0] wd;
    int         busy_cyc;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_code = C_RCV; wr_data = 8'h5A;
    @(posedge clk); #1 cmd_valid = 1'b0;
    repeat (10) @(negedge clk);
    vec_cnt++; if (state_debug !== 3'd4 || data_line !== 1'b1) begin
      err_cnt++; $display("FAIL ab_pre got st=%0d line=%b exp 4,1", state_debug, data_line); end
    #1 reset = 1'b0;
    #1;
    vec_cnt++; if (dut.oe_q !== 1'b1 || data_line !== 1'b0) begin
      err_cnt++; $display("FAIL ab_line got oe=%b line=%b exp 1,0", dut.oe_q, data_line); end
    vec_cnt++; if ({state_debug, busy, cmd_ready, rd_valid} !== 6'b000_000 || rd_data !== 8'h00) begin
      err_cnt++; $display("FAIL ab_state got st=%0d busy=%b rdy=%b rv=%b data=%h exp 0,0,0,0,00", state_debug, busy, cmd_ready, rd_valid, rd_data); end
    repeat (3) begin
      @(negedge clk);
      vec_cnt++; if (rd_valid !== 1'b0 || state_debug !== 3'd0) begin
        err_cnt++; $display("FAIL ab_hold got rv=%b st=%0d exp 0,0", rd_valid, state_debug); end
    end
    reset = 1'b1;
    @(negedge clk);
    vec_cnt++; if (cmd_ready !== 1'b1) begin
      err_cnt++; $display("FAIL ab_ready got=%b exp=1", cmd_ready); end
    wd = 8'hC3; busy_cyc = 0;
    cmd_valid = 1'b1; cmd_code = C_RCV; wr_data = wd;
    @(posedge clk); #1 cmd_valid = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cyc++;
      if (k >= 6 && k <= 13) begin
        vec_cnt++; if (dut.oe_q !== 1'b1 || data_line !== wd[13-k]) begin
          err_cnt++; $display("FAIL ab_wr_line cyc=%0d got oe=%b line=%b exp 1,%b", k, dut.oe_q, data_line, wd[13-k]); end
      end
      if (k == 16) begin
        vec_cnt++; if (cmd_ready !== 1'b1) begin err_cnt++; $display("FAIL ab_next_ready got=%b exp=1", cmd_ready); end
      end
    end
    vec_cnt++; if (busy_cyc != 15) begin
      err_cnt++; $display("FAIL ab_next_len got=%0d exp=15", busy_cyc); end
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_code = 2'd0; wr_data = 8'h00;
    tb_oe = 1'b0; tb_val = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_ignore_busy();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
